demux1to2_l2: RTL and testbench



---
 rtl/demux1to2_l2.sv | 195 +++++++++++++++++++
 tb/tb_demux1to2_l2.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/demux1to2_l2.sv
// ---------------------------------------------------------------------------
// demux1to2_l2
//
// Purpose:
//   Receive-side L2 byte demultiplexer. Takes the single interleaved byte
//   stream running at clk_4f and splits it back into two lanes. Valid bytes
//   alternate lane 0, lane 1, lane 0, ... A lane-0 byte is parked until its
//   lane-1 partner arrives, and then both lanes are presented together for one
//   cycle. If the partner never shows up within TIMEOUT idle cycles, the lone
//   lane-0 byte is flushed on its own and pair_err pulses.
//
// Parameters:
//   WIDTH    data width of the input and of each lane
//   TIMEOUT  idle cycles in WAIT1 before a lone lane-0 byte is flushed
//            (0 disables the flush)
//   CNT_W    idle counter width; 2**CNT_W must exceed TIMEOUT
//
// Ports:
//   clk_4f      in   sole clock, rising edge
//   reset       in   synchronous, active-high reset
//   data_in     in   interleaved input byte
//   valid_in    in   data_in is valid this cycle
//   data_out0   out  lane 0 byte (holds when valid_out0 is low)
//   data_out1   out  lane 1 byte (holds when valid_out1 is low)
//   valid_out0  out  one-cycle pulse, data_out0 valid
//   valid_out1  out  one-cycle pulse, data_out1 valid
//   pair_err    out  one-cycle pulse, lone lane-0 byte flushed by timeout
//
// Optional feature (macro DEMUX_L2_STATS_EN):
//   pair_count  out  16-bit count of completed pairs, wraps
//   err_count   out  8-bit count of pair_err events, saturates at 0xFF
//
// All outputs are registered; there is no combinational input-to-output path.
// ---------------------------------------------------------------------------
module demux1to2_l2 #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] data_out0,
  output logic [WIDTH-1:0] data_out1,
  output logic             valid_out0,
  output logic             valid_out1,
  output logic             pair_err
`ifdef DEMUX_L2_STATS_EN
  ,
  output logic [15:0]      pair_count,
  output logic [7:0]       err_count
`endif
);

  typedef enum logic {
    WAIT0 = 1'b0,
    WAIT1 = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hold0_q, hold0_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [WIDTH-1:0]   data_out0_q, data_out0_d;
  logic [WIDTH-1:0]   data_out1_q, data_out1_d;
  logic               valid_out0_q, valid_out0_d;
  logic               valid_out1_q, valid_out1_d;
  logic               pair_err_q, pair_err_d;

  // The timeout fires on the idle cycle that would bring the count up to
  // TIMEOUT. A zero TIMEOUT disables it entirely, so the cast of TIMEOUT-1
  // is never relied upon in that case.
  logic timeout_hit;
  assign timeout_hit = (TIMEOUT != 0) &&
                       (idle_cnt_q == CNT_W'(TIMEOUT - 1));

  // State register plus every registered output; reset discards any parked
  // lane-0 byte without producing an output.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q      <= WAIT0;
      hold0_q      <= '0;
      idle_cnt_q   <= '0;
      data_out0_q  <= '0;
      data_out1_q  <= '0;
      valid_out0_q <= 1'b0;
      valid_out1_q <= 1'b0;
      pair_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold0_q      <= hold0_d;
      idle_cnt_q   <= idle_cnt_d;
      data_out0_q  <= data_out0_d;
      data_out1_q  <= data_out1_d;
      valid_out0_q <= valid_out0_d;
      valid_out1_q <= valid_out1_d;
      pair_err_q   <= pair_err_d;
    end
  end

  // Next-state logic. In WAIT1 a valid byte always completes the pair, even
  // on the cycle the timeout would otherwise fire.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT0: begin
        if (valid_in) begin
          state_d = WAIT1;
        end
      end
      WAIT1: begin
        if (valid_in || timeout_hit) begin
          state_d = WAIT0;
        end
      end
      default: state_d = WAIT0;
    endcase
  end

  // Output and datapath next values. Data registers keep their last value
  // unless their lane is being presented; valids and pair_err default low so
  // they can only ever pulse for a single cycle.
  always_comb begin
    hold0_d      = hold0_q;
    idle_cnt_d   = idle_cnt_q;
    data_out0_d  = data_out0_q;
    data_out1_d  = data_out1_q;
    valid_out0_d = 1'b0;
    valid_out1_d = 1'b0;
    pair_err_d   = 1'b0;
    case (state_q)
      WAIT0: begin
        if (valid_in) begin
          hold0_d    = data_in;
          idle_cnt_d = '0;
        end
      end
      WAIT1: begin
        if (valid_in) begin
          data_out0_d  = hold0_q;
          data_out1_d  = data_in;
          valid_out0_d = 1'b1;
          valid_out1_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
          if (timeout_hit) begin
            data_out0_d  = hold0_q;
            valid_out0_d = 1'b1;
            pair_err_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign data_out0  = data_out0_q;
  assign data_out1  = data_out1_q;
  assign valid_out0 = valid_out0_q;
  assign valid_out1 = valid_out1_q;
  assign pair_err   = pair_err_q;

`ifdef DEMUX_L2_STATS_EN
  logic [15:0] pair_count_q, pair_count_d;
  logic [7:0]  err_count_q, err_count_d;

  // A completed pair is the only event that raises both valids together; a
  // flush raises valid_out0 alone together with pair_err.
  always_comb begin
    pair_count_d = pair_count_q;
    err_count_d  = err_count_q;
    if (valid_out0_d && valid_out1_d) begin
      pair_count_d = pair_count_q + 16'd1;
    end
    if (pair_err_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // Statistics registers, cleared alongside the rest of the block.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      pair_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      pair_count_q <= pair_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign pair_count = pair_count_q;
  assign err_count  = err_count_q;
`endif

endmodule

// File: tb/tb_demux1to2_l2.sv
// ---------------------------------------------------------------------------
// tb_demux1to2_l2
//
// Directed bench for demux1to2_l2. Each directed step drives one clk_4f
// cycle of input; any output event the step should cause is pushed to a
// scoreboard queue beforehand, and the queue front is popped and compared
// once the DUT has had its edge. Cycles without an expected event check that
// valids and pair_err are low and that the data outputs held their values.
// ---------------------------------------------------------------------------
module tb_demux1to2_l2;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned CNT_W   = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic [WIDTH-1:0] data_out0;
  logic [WIDTH-1:0] data_out1;
  logic             valid_out0;
  logic             valid_out1;
  logic             pair_err;
`ifdef DEMUX_L2_STATS_EN
  logic [15:0]      pair_count;
  logic [7:0]       err_count;
`endif

  demux1to2_l2 #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_4f     (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .pair_err   (pair_err)
`ifdef DEMUX_L2_STATS_EN
    ,
    .pair_count (pair_count),
    .err_count  (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic       v0;
    logic       v1;
    logic       err;
    logic [7:0] d0;
    logic [7:0] d1;
  } evt_t;

  evt_t       sb[$];
  int         cycle       = 0;
  int         assertCount = 0;
  int         failCount   = 0;
  logic [7:0] expData0    = 8'h00;
  logic [7:0] expData1    = 8'h00;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkEq(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue an output event to appear right after the next clock edge.
  task automatic expectEvent(input logic v0, input logic v1, input logic err,
                             input logic [7:0] d0, input logic [7:0] d1);
    evt_t e;
    e.due = cycle + 1;
    e.v0  = v0;
    e.v1  = v1;
    e.err = err;
    e.d0  = d0;
    e.d1  = d1;
    sb.push_back(e);
  endtask

  // Compare the outputs seen after the latest edge against the scoreboard.
  task automatic checkOutput(input logic wasReset);
    evt_t e;
    if (wasReset) begin
      sb.delete();
      expData0 = 8'h00;
      expData1 = 8'h00;
    end
    e.due = cycle;
    e.v0  = 1'b0;
    e.v1  = 1'b0;
    e.err = 1'b0;
    e.d0  = expData0;
    e.d1  = expData1;
    if (sb.size() > 0 && sb[0].due <= cycle) begin
      e = sb.pop_front();
      checkEq($sformatf("c%0d event_due", cycle), 16'(e.due), 16'(cycle));
    end
    if (e.v0) expData0 = e.d0;
    if (e.v1) expData1 = e.d1;
    checkEq($sformatf("c%0d valid_out0", cycle), 16'(valid_out0), 16'(e.v0));
    checkEq($sformatf("c%0d valid_out1", cycle), 16'(valid_out1), 16'(e.v1));
    checkEq($sformatf("c%0d pair_err", cycle), 16'(pair_err), 16'(e.err));
    checkEq($sformatf("c%0d data_out0", cycle), 16'(data_out0), 16'(expData0));
    checkEq($sformatf("c%0d data_out1", cycle), 16'(data_out1), 16'(expData1));
  endtask

  // Drive one cycle of input away from the active edge, then check.
  task automatic applyStimulus(input logic rst, input logic v,
                               input logic [7:0] d);
    @(negedge clk);
    reset    = rst;
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    cycle++;
    #1;
    checkOutput(rst);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic sendPair(input logic [7:0] b0, input logic [7:0] b1);
    applyStimulus(1'b0, 1'b1, b0);
    expectEvent(1'b1, 1'b1, 1'b0, b0, b1);
    applyStimulus(1'b0, 1'b1, b1);
  endtask

  task automatic sendFlush(input logic [7:0] b0);
    applyStimulus(1'b0, 1'b1, b0);
    idle(TIMEOUT - 1);
    expectEvent(1'b1, 1'b0, 1'b1, b0, 8'h00);
    idle(1);
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;

    $display("[TB] reset with valid traffic");
    applyStimulus(1'b1, 1'b1, 8'hAA);
    applyStimulus(1'b1, 1'b1, 8'hAA);

    $display("[TB] back-to-back streaming");
    sendPair(8'h01, 8'h02);
    sendPair(8'h03, 8'h04);
    idle(1);

    $display("[TB] gapped pair");
    applyStimulus(1'b0, 1'b1, 8'h10);
    idle(3);
    expectEvent(1'b1, 1'b1, 1'b0, 8'h10, 8'h20);
    applyStimulus(1'b0, 1'b1, 8'h20);
    idle(2);

    $display("[TB] timeout flush, next byte is lane 0");
    sendFlush(8'h55);
    sendPair(8'h66, 8'h67);
    idle(1);

    $display("[TB] partner arrives on the timeout cycle");
    applyStimulus(1'b0, 1'b1, 8'h5A);
    idle(TIMEOUT - 1);
    expectEvent(1'b1, 1'b1, 1'b0, 8'h5A, 8'h5B);
    applyStimulus(1'b0, 1'b1, 8'h5B);
    idle(TIMEOUT + 1);

    $display("[TB] reset mid-pair");
    applyStimulus(1'b0, 1'b1, 8'h77);
    applyStimulus(1'b1, 1'b0, 8'h00);
    sendPair(8'h88, 8'h99);
    idle(1);

    $display("[TB] two more pairs and one flush");
    sendFlush(8'h31);
    sendPair(8'h41, 8'h42);
    idle(2);
    sendPair(8'h43, 8'h44);
    idle(2);

`ifdef DEMUX_L2_STATS_EN
    checkEq("pair_count", pair_count, 16'd3);
    checkEq("err_count", 16'(err_count), 16'd1);
`endif
    checkEq("scoreboard_drained", 16'(sb.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
